// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and elaboration-time helpers for the slave memory.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int clog2(input int unsigned v);
        int unsigned p;
        int          r;
        p = 1;
        r = 0;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address and burst legality for one AXI channel (purely combinational).
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              illegal_o
);

    localparam logic [2:0]        MAX_SIZE = 3'(clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] boundary;
    logic [2:0]        wrap_sh;
    logic              wrap_len_ok;

    always_comb begin
        bytes       = ONE << size_i;
        wrap_len_ok = 1'b1;
        wrap_sh     = 3'd1;
        case (len_i)
            8'd1:    wrap_sh = 3'd1;
            8'd3:    wrap_sh = 3'd2;
            8'd7:    wrap_sh = 3'd3;
            8'd15:   wrap_sh = 3'd4;
            default: wrap_len_ok = 1'b0;
        endcase
        // span = bytes*(len+1) is a power of two for every legal wrap length
        span     = bytes << wrap_sh;
        boundary = start_i & ~(span - ONE);

        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = (addr_i & ~(bytes - ONE)) + bytes;
            BURST_WRAP:  next_addr_o = boundary + ((addr_i + bytes - boundary) & (span - ONE));
            default:     next_addr_o = addr_i;
        endcase

        illegal_o = (burst_i == BURST_RSVD) || (size_i > MAX_SIZE)
                    || ((burst_i == BURST_WRAP) && !wrap_len_ok);
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4-full slave memory with independent write and read FSMs over a byte-lane array.
// Read payload is registered per beat so it holds steady under R backpressure.
//
// state  | meaning
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, writing one beat per W handshake
// W_RESP | bvalid high with the accumulated response, waiting for bready
// R_IDLE | arready high, waiting for an AR handshake
// R_DATA | rvalid high, presenting the registered beat until rready
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       MEM_BYTES = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                aclk,
    input  logic                aresetn,

    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,

    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,

    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,

    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,

    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int unsigned       STRB_W   = DATA_W / 8;
    localparam int unsigned       BYTE_SH  = clog2(STRB_W);
    localparam int unsigned       WORDS    = MEM_BYTES / STRB_W;
    localparam int unsigned       WIDX_W   = (clog2(WORDS) > 0) ? clog2(WORDS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(MEM_BYTES - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // BASE_ADDR is aligned to MEM_BYTES, so a mask compare is an exact window test
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a & ~OFF_MASK) == BASE_ADDR;
    endfunction

    function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> BYTE_SH;
        return WIDX_W'(off);
    endfunction

    logic [DATA_W-1:0] mem_q [WORDS];

    // holds the ready outputs low while reset is sampled
    logic live_q;

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] w_start_q, w_start_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [2:0]        w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [7:0]        w_left_q, w_left_d;
    logic [1:0]        w_resp_q, w_resp_d;
    logic [ADDR_W-1:0] w_next;
    logic              w_illegal;
    logic              w_we;
    logic [1:0]        w_beat_err;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] r_start_q, r_start_d;
    logic [7:0]        r_len_q, r_len_d;
    logic [2:0]        r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [7:0]        r_left_q, r_left_d;
    logic              r_bad_q, r_bad_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q;
    logic              r_load;
    logic              r_done;
    logic              r_idle;
    logic [ADDR_W-1:0] r_next;
    logic              r_illegal;

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_addr (
        .addr_i      (w_addr_q),
        .start_i     (w_start_q),
        .len_i       (w_len_q),
        .size_i      (w_size_q),
        .burst_i     (w_burst_q),
        .next_addr_o (w_next),
        .illegal_o   (w_illegal)
    );

    // in R_IDLE the checker looks at the incoming AR fields so legality latches at the handshake
    assign r_idle = (r_state_q == R_IDLE);

    axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_addr (
        .addr_i      (r_idle ? araddr  : r_addr_q),
        .start_i     (r_idle ? araddr  : r_start_q),
        .len_i       (r_idle ? arlen   : r_len_q),
        .size_i      (r_idle ? arsize  : r_size_q),
        .burst_i     (r_idle ? arburst : r_burst_q),
        .next_addr_o (r_next),
        .illegal_o   (r_illegal)
    );

    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_start_d  = w_start_q;
        w_len_d    = w_len_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_left_d   = w_left_q;
        w_resp_d   = w_resp_q;
        w_we       = 1'b0;
        w_beat_err = RESP_OKAY;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                awready = live_q;
                if (awvalid && live_q) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_start_d = awaddr;
                    w_len_d   = awlen;
                    w_size_d  = awsize;
                    w_burst_d = awburst;
                    w_left_d  = awlen;
                    w_resp_d  = RESP_OKAY;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (w_illegal) begin
                    w_beat_err = RESP_SLVERR;
                end else if (!in_range(w_addr_q)) begin
                    w_beat_err = RESP_DECERR;
                end else if (wlast != (w_left_q == 8'd0)) begin
                    w_beat_err = RESP_SLVERR;
                end
                if (wvalid) begin
                    w_we     = !w_illegal && in_range(w_addr_q);
                    w_addr_d = w_next;
                    w_left_d = w_left_q - 8'd1;
                    if (w_resp_q == RESP_OKAY) begin
                        w_resp_d = w_beat_err;
                    end
                    if (w_left_q == 8'd0) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign bid   = w_id_q;
    assign bresp = w_resp_q;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_start_d = r_start_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_left_d  = r_left_q;
        r_bad_d   = r_bad_q;
        r_load    = 1'b0;
        r_done    = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                arready = live_q;
                if (arvalid && live_q) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_start_d = araddr;
                    r_len_d   = arlen;
                    r_size_d  = arsize;
                    r_burst_d = arburst;
                    r_left_d  = arlen;
                    r_bad_d   = r_illegal;
                    r_load    = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (r_left_q == 8'd0) begin
                        r_done    = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_next;
                        r_left_d = r_left_q - 8'd1;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // the beat is fetched at the edge it is loaded, so a same-edge write is not visible
    always_comb begin
        if (r_bad_d) begin
            rresp_d = RESP_SLVERR;
        end else if (!in_range(r_addr_d)) begin
            rresp_d = RESP_DECERR;
        end else begin
            rresp_d = RESP_OKAY;
        end
        rdata_d = (rresp_d == RESP_OKAY) ? mem_q[word_idx(r_addr_d)] : '0;
    end

    assign rid   = r_id_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign rlast = rlast_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_start_q <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_left_q  <= '0;
            w_resp_q  <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_start_q <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_left_q  <= '0;
            r_bad_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_start_q <= w_start_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_left_q  <= w_left_d;
            w_resp_q  <= w_resp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_start_q <= r_start_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_left_q  <= r_left_d;
            r_bad_q   <= r_bad_d;
            if (r_load) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
                rlast_q <= (r_left_d == 8'd0);
            end else if (r_done) begin
                rlast_q <= 1'b0;
            end
        end
    end

    // contents survive reset; a write is dropped on the edge reset is sampled
    always_ff @(posedge aclk) begin
        if (aresetn && w_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, error responses, backpressure and reset.
module tb_axi_slave_mem;

    localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic        aclk, aresetn;
    logic [3:0]  awid;    logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic awvalid, awready;
    logic [31:0] wdata;   logic [3:0] wstrb; logic wlast, wvalid, wready;
    logic [3:0]  bid;     logic [1:0] bresp; logic bvalid, bready;
    logic [3:0]  arid;    logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic arvalid, arready;
    logic [3:0]  rid;     logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic [31:0] exp_d [4];

    axi_slave_mem #(
        .DATA_W(32), .ID_W(4), .ADDR_W(32), .MEM_BYTES(4096), .BASE_ADDR(32'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int last_at,
                               input int b_hold, output logic [1:0] resp, output logic [3:0] id_o);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin step(); n++; end
        chk("aw_ready_seen", awready, 1'b1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin step(); n++; end
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; end
        chk("b_valid_seen", bvalid, 1'b1);
        for (int c = 0; c < b_hold; c++) begin
            chk("b_hold_bvalid", bvalid, 1'b1);
            chk("b_hold_awready", awready, 1'b0);
            step();
        end
        resp = bresp; id_o = bid;
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int n;
        logic [31:0] snap_d;
        logic        snap_l;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        chk("ar_ready_seen", arready, 1'b1);
        step();
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!rvalid && n < 50) begin step(); n++; end
            if (stall) begin
                rready = 1'b0;
                snap_d = rdata; snap_l = rlast;
                step(); step();
                chk("r_stall_data", rdata, snap_d);
                chk("r_stall_last", rlast, snap_l);
                chk("r_stall_valid", rvalid, 1'b1);
            end
            rready = 1'b1;
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id = rid;
            step();
            rready = 1'b0;
        end
        chk("r_end_valid", rvalid, 1'b0);
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) step();

        chk("rst_awready", awready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rlast",   rlast,   1'b0);
        chk("rst_bid_bresp", {bid, bresp}, 6'h0);
        chk("rst_rid_rresp", {rid, rresp}, 6'h0);
        chk("rst_rdata",   rdata,   32'h0);
        aresetn = 1'b1;
        step();
        chk("rel_awready", awready, 1'b1);
        chk("rel_arready", arready, 1'b1);

        // INCR write then INCR read back
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        wr_data[2] = 32'h33333333; wr_data[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
        write_burst(4'h5, 32'h100, 8'd3, 3'd2, INC, 3, 0, b_resp, b_id);
        chk("incr_w_bresp", b_resp, OKAY);
        chk("incr_w_bid", b_id, 4'h5);
        read_burst(4'h3, 32'h100, 8'd3, 3'd2, INC, 1'b0);
        chk("incr_r_rid", rd_id, 4'h3);
        for (int i = 0; i < 4; i++) begin
            chk("incr_r_data", rd_data[i], wr_data[i]);
            chk("incr_r_resp", rd_resp[i], OKAY);
            chk("incr_r_last", rd_last[i], (i == 3));
        end

        // WRAP read from 0x108: 0x108, 0x10C, 0x100, 0x104
        exp_d[0] = 32'h33333333; exp_d[1] = 32'h44444444;
        exp_d[2] = 32'h11111111; exp_d[3] = 32'h22222222;
        read_burst(4'h2, 32'h108, 8'd3, 3'd2, WRP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_r_data", rd_data[i], exp_d[i]);
            chk("wrap_r_resp", rd_resp[i], OKAY);
        end

        // FIXED write, one lane per beat, all to 0x200
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hAABBCCDD;
        wr_strb[0] = 4'h1; wr_strb[1] = 4'h2; wr_strb[2] = 4'h4; wr_strb[3] = 4'h8;
        write_burst(4'h1, 32'h200, 8'd3, 3'd2, FIX, 3, 0, b_resp, b_id);
        chk("fixed_w_bresp", b_resp, OKAY);
        read_burst(4'h1, 32'h200, 8'd0, 3'd2, INC, 1'b0);
        chk("fixed_r_data", rd_data[0], 32'hAABBCCDD);

        // out-of-range write must not alias onto word 0
        wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
        write_burst(4'h0, 32'h000, 8'd0, 3'd2, INC, 0, 0, b_resp, b_id);
        chk("w0_bresp", b_resp, OKAY);
        wr_data[0] = 32'hDEADBEEF;
        write_burst(4'h6, 32'h1000, 8'd0, 3'd2, INC, 0, 0, b_resp, b_id);
        chk("decerr_w_bresp", b_resp, DECERR);
        chk("decerr_w_bid", b_id, 4'h6);
        read_burst(4'h0, 32'h000, 8'd0, 3'd2, INC, 1'b0);
        chk("decerr_mem_kept", rd_data[0], 32'h12345678);
        read_burst(4'h0, 32'h1000, 8'd0, 3'd2, INC, 1'b0);
        chk("decerr_r_resp", rd_resp[0], DECERR);
        chk("decerr_r_data", rd_data[0], 32'h0);

        // reserved burst type and illegal wrap length
        read_burst(4'h7, 32'h100, 8'd1, 3'd2, RSV, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rsv_r_resp", rd_resp[i], SLVERR);
            chk("rsv_r_data", rd_data[i], 32'h0);
        end
        read_burst(4'h7, 32'h100, 8'd2, 3'd2, WRP, 1'b0);
        chk("wraplen_r_resp", rd_resp[0], SLVERR);

        // wlast protocol errors and oversize write
        wr_data[0] = 32'h0; wr_data[1] = 32'h0; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        write_burst(4'h2, 32'h400, 8'd1, 3'd2, INC, 0, 0, b_resp, b_id);
        chk("early_wlast_bresp", b_resp, SLVERR);
        write_burst(4'h2, 32'h400, 8'd1, 3'd2, INC, 5, 0, b_resp, b_id);
        chk("missing_wlast_bresp", b_resp, SLVERR);
        wr_data[0] = 32'hFFFFFFFF;
        write_burst(4'h2, 32'h100, 8'd0, 3'd3, INC, 0, 0, b_resp, b_id);
        chk("size_w_bresp", b_resp, SLVERR);
        read_burst(4'h2, 32'h100, 8'd0, 3'd2, INC, 1'b0);
        chk("size_mem_kept", rd_data[0], 32'h11111111);

        // B backpressure for 5 cycles
        wr_data[0] = 32'h0BADF00D;
        write_burst(4'h9, 32'h300, 8'd0, 3'd2, INC, 0, 5, b_resp, b_id);
        chk("bp_bresp", b_resp, OKAY);
        chk("bp_bid", b_id, 4'h9);

        // R backpressure on every beat
        read_burst(4'h4, 32'h100, 8'd3, 3'd2, INC, 1'b1);
        exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
        exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            chk("stall_r_data", rd_data[i], exp_d[i]);
            chk("stall_r_last", rd_last[i], (i == 3));
        end

        // reset in the middle of an 8-beat read
        arid = 4'h8; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = INC; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        rready = 1'b1;
        step(); step();
        aresetn = 1'b0;
        step();
        chk("midrst_rvalid", rvalid, 1'b0);
        chk("midrst_arready", arready, 1'b0);
        chk("midrst_rlast", rlast, 1'b0);
        rready = 1'b0;
        aresetn = 1'b1;
        step();
        chk("midrst_arready_up", arready, 1'b1);
        read_burst(4'h8, 32'h100, 8'd3, 3'd2, INC, 1'b0);
        for (int i = 0; i < 4; i++) chk("midrst_mem_kept", rd_data[i], exp_d[i]);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
